uart_rx_pkt_ctrl: RTL and testbench

UART_RX_PKT_CTRL -- requirements
Module: uart_rx_pkt_ctrl

---
 rtl/uart_rx_pkt_ctrl.sv | 155 +++++++++++++++
 tb/tb_uart_rx_pkt_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind a UART receiver: SYNC, LEN, payload, additive checksum.
// Optional inter-byte timeout compiled in with `define UART_RX_PKT_TIMEOUT_EN.
module uart_rx_pkt_ctrl #(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_last,
  output logic       pkt_ok,
  output logic       pkt_err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CKSUM} state_t;

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] sum_q, sum_d;
  logic [7:0] dout_q, dout_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       ok_q, ok_d;
  logic       err_q, err_d;
  logic [1:0] code_q, code_d;
  logic [7:0] sum_ck;
  logic       tmo_hit;

  assign sum_ck = sum_q + din;

`ifdef UART_RX_PKT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  logic [TW-1:0] tmo_q;

  assign tmo_hit = s_tick && (state_q != S_HUNT) && (tmo_q == TW'(TIMEOUT_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset || rx_done_tick || state_q == S_HUNT || tmo_hit) tmo_q <= '0;
    else if (s_tick)                                           tmo_q <= tmo_q + 1'b1;
  end
`else
  localparam int unsigned unused_timeout_ticks = TIMEOUT_TICKS;
  logic unused_s_tick;
  assign unused_s_tick = s_tick;
  assign tmo_hit       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    last_d  = last_q;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    if (valid_q && dout_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
    // A received byte always wins over a timeout in the same cycle.
    if (rx_done_tick) begin
      case (state_q)
        S_HUNT: if (din == SYNC_BYTE) state_d = S_LEN;
        S_LEN: begin
          if (din == 8'd0 || din > MAX_LEN_B) begin
            err_d   = 1'b1;
            code_d  = 2'b01;
            state_d = S_HUNT;
          end else begin
            cnt_d   = din;
            sum_d   = din;
            state_d = S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (valid_q && !dout_ready) begin
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = S_HUNT;
          end else begin
            sum_d   = sum_ck;
            dout_d  = din;
            valid_d = 1'b1;
            last_d  = (cnt_q == 8'd1);
            cnt_d   = cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_d = S_CKSUM;
          end
        end
        S_CKSUM: begin
          if (sum_ck == 8'd0) begin
            ok_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b10;
          end
          state_d = S_HUNT;
        end
        default: state_d = S_HUNT;
      endcase
    end else if (tmo_hit) begin
      err_d   = 1'b1;
      code_d  = 2'b00;
      state_d = S_HUNT;
    end
    if (err_d) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_HUNT;
      cnt_q   <= '0;
      sum_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_last  = last_q;
  assign pkt_ok     = ok_q;
  assign pkt_err    = err_q;
  assign err_code   = code_q;
  assign busy       = (state_q != S_HUNT);

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl; bytes are driven on the falling edge
// and results sampled on the next falling edge (one cycle after capture).
module tb_uart_rx_pkt_ctrl;

  logic       clk = 1'b0;
  logic       reset, s_tick, rx_done_tick, dout_ready;
  logic [7:0] din;
  logic [7:0] dout;
  logic       dout_valid, dout_last, pkt_ok, pkt_err, busy;
  logic [1:0] err_code;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_pkt_ctrl #(
    .SYNC_BYTE    (8'hA5),
    .MAX_LEN      (16),
    .TIMEOUT_TICKS(640)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx_done_tick(rx_done_tick),
    .din         (din),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .dout_ready  (dout_ready),
    .dout_last   (dout_last),
    .pkt_ok      (pkt_ok),
    .pkt_err     (pkt_err),
    .err_code    (err_code),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    @(negedge clk);
    din          = b;
    dout_ready   = rdy;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      s_tick = 1'b1;
    end
    @(negedge clk);
    s_tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; s_tick = 1'b0; rx_done_tick = 1'b0; din = '0; dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_dout",  dout, 8'h00);
    check_eq("rst_valid", dout_valid, 1'b0);
    check_eq("rst_last",  dout_last, 1'b0);
    check_eq("rst_ok",    pkt_ok, 1'b0);
    check_eq("rst_err",   pkt_err, 1'b0);
    check_eq("rst_code",  err_code, 2'b00);
    check_eq("rst_busy",  busy, 1'b0);
    reset = 1'b0;

    // Good frame: 03+11+22+33 = 69, so the balancing checksum is 97.
    send(8'hA5, 1'b1); check_eq("f1_busy", busy, 1'b1);
    send(8'h03, 1'b1);
    send(8'h11, 1'b1); check_eq("f1_d0", dout, 8'h11); check_eq("f1_v0", dout_valid, 1'b1);
    check_eq("f1_l0", dout_last, 1'b0);
    send(8'h22, 1'b1); check_eq("f1_d1", dout, 8'h22); check_eq("f1_l1", dout_last, 1'b0);
    send(8'h33, 1'b1); check_eq("f1_d2", dout, 8'h33); check_eq("f1_l2", dout_last, 1'b1);
    send(8'h97, 1'b1); check_eq("f1_ok", pkt_ok, 1'b1); check_eq("f1_err", pkt_err, 1'b0);
    check_eq("f1_busy_end", busy, 1'b0); check_eq("f1_v_end", dout_valid, 1'b0);
    @(negedge clk); check_eq("f1_ok_pulse", pkt_ok, 1'b0);

    // Bad checksum: 02+10+20 = 32, CK 00 does not balance.
    send(8'hA5, 1'b1); send(8'h02, 1'b1);
    send(8'h10, 1'b1); check_eq("f2_d0", dout, 8'h10);
    send(8'h20, 1'b1); check_eq("f2_d1", dout, 8'h20); check_eq("f2_l1", dout_last, 1'b1);
    send(8'h00, 1'b1); check_eq("f2_err", pkt_err, 1'b1); check_eq("f2_code", err_code, 2'b10);
    check_eq("f2_ok", pkt_ok, 1'b0); check_eq("f2_valid", dout_valid, 1'b0);
    @(negedge clk); check_eq("f2_err_pulse", pkt_err, 1'b0);

    // Junk before sync is dropped; SYNC value inside the frame is payload.
    send(8'h00, 1'b1); send(8'hFF, 1'b1); check_eq("f3_hunt", busy, 1'b0);
    send(8'hA5, 1'b1); send(8'h01, 1'b1);
    send(8'hA5, 1'b1); check_eq("f3_d", dout, 8'hA5); check_eq("f3_last", dout_last, 1'b1);
    check_eq("f3_valid", dout_valid, 1'b1);
    send(8'h5A, 1'b1); check_eq("f3_ok", pkt_ok, 1'b1); check_eq("f3_code_hold", err_code, 2'b10);

    // Length bounds.
    send(8'hA5, 1'b1); send(8'h00, 1'b1);
    check_eq("len0_err", pkt_err, 1'b1); check_eq("len0_code", err_code, 2'b01);
    check_eq("len0_busy", busy, 1'b0);
    send(8'hA5, 1'b1); send(8'h11, 1'b1);
    check_eq("len17_err", pkt_err, 1'b1); check_eq("len17_code", err_code, 2'b01);
    check_eq("len17_busy", busy, 1'b0);

    // Held byte, then a new byte arriving together with acceptance.
    send(8'hA5, 1'b0); send(8'h02, 1'b0);
    send(8'h10, 1'b0); check_eq("bp_d0", dout, 8'h10);
    repeat (3) @(negedge clk);
    check_eq("bp_hold", dout_valid, 1'b1);
    send(8'h20, 1'b1); check_eq("bp_d1", dout, 8'h20); check_eq("bp_v1", dout_valid, 1'b1);
    check_eq("bp_l1", dout_last, 1'b1); check_eq("bp_noerr", pkt_err, 1'b0);
    @(negedge clk); check_eq("bp_clear", dout_valid, 1'b0); check_eq("bp_lclear", dout_last, 1'b0);
    send(8'hCE, 1'b1); check_eq("bp_ok", pkt_ok, 1'b1);

    // Overrun.
    send(8'hA5, 1'b0); send(8'h02, 1'b0);
    send(8'h55, 1'b0); check_eq("ov_v", dout_valid, 1'b1); check_eq("ov_d", dout, 8'h55);
    send(8'h66, 1'b0); check_eq("ov_err", pkt_err, 1'b1); check_eq("ov_code", err_code, 2'b11);
    check_eq("ov_valid", dout_valid, 1'b0); check_eq("ov_busy", busy, 1'b0);

    // Stalled frame.
    send(8'hA5, 1'b1); send(8'h04, 1'b1); send(8'h01, 1'b1);
    ticks(639);
    check_eq("to_pre_err", pkt_err, 1'b0); check_eq("to_pre_busy", busy, 1'b1);
    ticks(1);
`ifdef UART_RX_PKT_TIMEOUT_EN
    check_eq("to_err", pkt_err, 1'b1); check_eq("to_code", err_code, 2'b00);
    check_eq("to_busy", busy, 1'b0);
    send(8'hA5, 1'b1); send(8'h10, 1'b1); send(8'h01, 1'b1);
`else
    check_eq("to_none", pkt_err, 1'b0); check_eq("to_busy", busy, 1'b1);
    check_eq("to_code", err_code, 2'b11);
`endif

    // Reset in the middle of a frame.
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    check_eq("mr_ok", pkt_ok, 1'b0); check_eq("mr_err", pkt_err, 1'b0);
    check_eq("mr_busy", busy, 1'b0); check_eq("mr_code", err_code, 2'b00);
    @(negedge clk); reset = 1'b0;
    check_eq("mr_ok2", pkt_ok, 1'b0); check_eq("mr_err2", pkt_err, 1'b0);

    // Maximum length: 10 + (1+..+16) = 98, balancing checksum 68.
    send(8'hA5, 1'b1); send(8'h10, 1'b1); check_eq("max_busy", busy, 1'b1);
    for (int unsigned i = 1; i <= 16; i++) begin
      send(8'(i), 1'b1);
      check_eq("max_d", dout, i);
      check_eq("max_last", dout_last, (i == 16) ? 1'b1 : 1'b0);
    end
    send(8'h68, 1'b1); check_eq("max_ok", pkt_ok, 1'b1); check_eq("max_noerr", pkt_err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
